// File: rtl/identifier_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : identifier_pkg
//  Brief    : Register map, state encoding and response codes shared by the
//             identifier register block and its read initiator.
//  Revision : 1.0 - initial release
// ============================================================================
package identifier_pkg;

   localparam logic [11:0] c_name0_offset   = 12'h004;
   localparam logic [11:0] c_name1_offset   = 12'h008;
   localparam logic [11:0] c_name2_offset   = 12'h00C;
   localparam logic [11:0] c_name3_offset   = 12'h010;
   localparam logic [11:0] c_version_offset = 12'h014;

   localparam int          c_num_words      = 5;
   localparam logic [1:0]  c_resp_okay      = 2'b00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   // Words are laid out contiguously from NAME0, so word idx sits at NAME0 + 4*idx.
   function automatic logic [11:0] word_offset(input logic [2:0] idx);
      return c_name0_offset + {7'd0, idx, 2'b00};
   endfunction

endpackage : identifier_pkg
`default_nettype wire

// File: rtl/identifier_reader.sv
`default_nettype none
// ============================================================================
//  Module   : identifier_reader
//  Brief    : AXI4-Lite read initiator that fetches the NAME and VERSION words
//             of an identifier block and compares them with expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module identifier_reader
   import identifier_pkg::*;
#(
   parameter logic [11:0]      BASE_ADDR = 12'h000,
   parameter bit [15:0][7:0]   EXP_NAME  = {96'h0, "TEST"},
   parameter logic [15:0]      EXP_MAJOR = 16'd1
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic          mismatch,
   output logic [127:0]  name,
   output logic [15:0]   major_version,
   output logic [15:0]   minor_version,
   output logic          m_arvalid,
   input  logic          m_arready,
   output logic [11:0]   m_araddr,
   input  logic          m_rvalid,
   output logic          m_rready,
   input  logic [31:0]   m_rdata,
   input  logic [1:0]    m_rresp
);

   state_t         r_state;
   logic [2:0]     r_idx;
   logic           r_busy;
   logic           r_done;
   logic           r_error;
   logic           r_mismatch;
   logic [127:0]   r_name;
   logic [15:0]    r_major;
   logic [15:0]    r_minor;
   logic           r_arvalid;
   logic [11:0]    r_araddr;
   logic           r_rready;

   logic           w_last_word;
   logic           w_resp_ok;
   logic [6:0]     w_name_lsb;
   logic           w_name_mismatch;
   logic           w_major_mismatch;

   assign w_last_word      = (r_idx == 3'(c_num_words - 1));
   assign w_resp_ok        = (m_rresp == c_resp_okay);
   // Word 0 occupies the top of the name, so slot (3 - idx) holds word idx.
   assign w_name_lsb       = {~r_idx[1:0], 5'd0};
   assign w_name_mismatch  = (r_name != EXP_NAME);
   assign w_major_mismatch = (m_rdata[31:16] != EXP_MAJOR);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= IDLE;
         r_idx      <= 3'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_mismatch <= 1'b0;
         r_name     <= '0;
         r_major    <= '0;
         r_minor    <= '0;
         r_arvalid  <= 1'b0;
         r_araddr   <= '0;
         r_rready   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_name     <= '0;
                  r_major    <= '0;
                  r_minor    <= '0;
                  r_error    <= 1'b0;
                  r_mismatch <= 1'b0;
                  r_idx      <= 3'd0;
                  r_busy     <= 1'b1;
                  r_arvalid  <= 1'b1;
                  r_araddr   <= BASE_ADDR + word_offset(3'd0);
                  r_state    <= ADDR;
               end
            end
            ADDR: begin
               if (m_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= DATA;
               end
            end
            DATA: begin
               if (m_rvalid) begin
                  r_rready <= 1'b0;
                  if (!w_resp_ok) begin
                     r_error    <= 1'b1;
                     r_mismatch <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= DONE;
                  end else if (w_last_word) begin
                     r_major    <= m_rdata[31:16];
                     r_minor    <= m_rdata[15:0];
                     r_mismatch <= w_name_mismatch || w_major_mismatch;
                     r_done     <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     r_name[w_name_lsb +: 32] <= m_rdata;
                     r_idx     <= r_idx + 3'd1;
                     r_arvalid <= 1'b1;
                     r_araddr  <= BASE_ADDR + word_offset(r_idx + 3'd1);
                     r_state   <= ADDR;
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign error         = r_error;
   assign mismatch      = r_mismatch;
   assign name          = r_name;
   assign major_version = r_major;
   assign minor_version = r_minor;
   assign m_arvalid     = r_arvalid;
   assign m_araddr      = r_araddr;
   assign m_rready      = r_rready;

endmodule : identifier_reader
`default_nettype wire

// File: tb/tb_identifier_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_identifier_reader
//  Brief    : Self-checking bench for identifier_reader with a configurable
//             AXI4-Lite slave model and an address scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_identifier_reader;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, error, mismatch;
   logic [127:0]  name;
   logic [15:0]   major_version, minor_version;
   logic          m_arvalid;
   logic          m_arready = 1'b0;
   logic [11:0]   m_araddr;
   logic          m_rvalid = 1'b0;
   logic          m_rready;
   logic [31:0]   m_rdata = '0;
   logic [1:0]    m_rresp = '0;

   identifier_reader dut (
      .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
      .error(error), .mismatch(mismatch), .name(name),
      .major_version(major_version), .minor_version(minor_version),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   localparam logic [127:0] c_test_name = {96'h0, 32'h5445_5354};

   typedef struct {
      int           ar_wait;
      int           r_wait;
      logic [31:0]  ver_word;
      logic [11:0]  err_addr;
      int           done_cyc;
      logic [15:0]  exp_major;
      logic [15:0]  exp_minor;
      logic         exp_err;
      logic         exp_mis;
      logic [127:0] exp_name;
      int           n_ars;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard of expected AR addresses, pushed at start and popped per handshake.
   logic [11:0] exp_q[$];

   int          ar_wait = 0;
   int          r_wait  = 0;
   logic [31:0] ver_word = 32'h0001_0000;
   logic [11:0] err_addr = 12'hFFF;
   int          ar_hs_cnt = 0;
   int          done_cnt  = 0;

   int          ar_cnt = 0;
   int          rd_cnt = 0;
   bit          rd_pend = 1'b0;
   logic [11:0] rd_addr = '0;
   logic        p_arvalid = 1'b0, p_arready = 1'b0, p_rvalid = 1'b0, p_rready = 1'b0;
   logic [11:0] p_araddr = '0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] slave_word(input logic [11:0] a);
      case (a)
         12'h010: return 32'h5445_5354;
         12'h014: return ver_word;
         default: return 32'h0;
      endcase
   endfunction

   // Slave model: decisions made on the falling edge from values that were
   // present at the preceding rising edge.
   always @(negedge aclk) begin
      if (!aresetn) begin
         ar_cnt = 0; rd_pend = 1'b0; rd_cnt = 0;
         m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
         p_arvalid = 1'b0; p_arready = 1'b0; p_rvalid = 1'b0; p_rready = 1'b0;
      end else begin
         if (p_arvalid && !p_arready) begin
            check("ar_hold_valid", 128'(m_arvalid), 128'd1);
            check("ar_hold_addr", 128'(m_araddr), 128'(p_araddr));
         end
         check("ar_r_exclusive", 128'(m_arvalid & m_rready), 128'd0);
         if (p_arvalid && p_arready) begin
            ar_hs_cnt++;
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL ar_unexpected: got %0h expected none", p_araddr);
            end else begin
               check("araddr", 128'(p_araddr), 128'(exp_q.pop_front()));
            end
            rd_pend = 1'b1; rd_cnt = r_wait; rd_addr = p_araddr;
         end
         if (p_rvalid && p_rready) rd_pend = 1'b0;

         m_arready = 1'b0;
         if (m_arvalid) begin
            if (ar_cnt < ar_wait) ar_cnt++;
            else begin m_arready = 1'b1; ar_cnt = 0; end
         end

         m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
         if (rd_pend) begin
            if (rd_cnt > 0) rd_cnt--;
            else begin
               m_rvalid = 1'b1;
               m_rdata  = slave_word(rd_addr);
               m_rresp  = (rd_addr == err_addr) ? 2'b10 : 2'b00;
            end
         end
         if (done) done_cnt++;
         p_arvalid = m_arvalid; p_arready = m_arready; p_araddr = m_araddr;
         p_rvalid  = m_rvalid;  p_rready  = m_rready;
      end
   end

   task automatic load(input vec_t v);
      ar_wait = v.ar_wait; r_wait = v.r_wait; ver_word = v.ver_word; err_addr = v.err_addr;
   endtask

   task automatic push_addrs(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(12'h004 + 12'(4 * i));
   endtask

   // Waits (bounded) for done and checks the captured results of one scan.
   task automatic wait_and_check(input vec_t v, input int t0);
      int k = 0;
      while (!done && k < 300) begin @(negedge aclk); k++; end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: got no done expected done at cycle %0d", v.done_cyc);
      end else begin
         check("done_cycle", 128'(cyc - t0), 128'(v.done_cyc));
         check("name", name, v.exp_name);
         check("major", 128'(major_version), 128'(v.exp_major));
         check("minor", 128'(minor_version), 128'(v.exp_minor));
         check("error", 128'(error), 128'(v.exp_err));
         check("mismatch", 128'(mismatch), 128'(v.exp_mis));
         check("busy_in_done", 128'(busy), 128'd1);
      end
      @(negedge aclk);
      check("done_one_cycle", 128'(done), 128'd0);
      check("busy_after_done", 128'(busy), 128'd0);
      check("error_held", 128'(error), 128'(v.exp_err));
      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int t0;
      load(v);
      @(negedge aclk);
      push_addrs(v.n_ars);
      start = 1'b1; t0 = cyc;
      @(negedge aclk);
      start = 1'b0;
      check("busy_after_start", 128'(busy), 128'd1);
      wait_and_check(v, t0);
   endtask

   vec_t vecs[5];

   initial begin
      int t0;
      int ar0, d0;
      vecs[0] = '{0, 0, 32'h0001_0000, 12'hFFF, 11, 16'd1, 16'd0, 1'b0, 1'b0, c_test_name, 5};
      vecs[1] = '{3, 2, 32'h0001_0000, 12'hFFF, 36, 16'd1, 16'd0, 1'b0, 1'b0, c_test_name, 5};
      vecs[2] = '{0, 0, 32'h0002_0007, 12'hFFF, 11, 16'd2, 16'd7, 1'b0, 1'b1, c_test_name, 5};
      vecs[3] = '{0, 0, 32'h0001_0009, 12'hFFF, 11, 16'd1, 16'd9, 1'b0, 1'b0, c_test_name, 5};
      vecs[4] = '{0, 0, 32'h0001_0000, 12'h00C, 7,  16'd0, 16'd0, 1'b1, 1'b0, 128'd0, 3};

      repeat (3) @(negedge aclk);
      check("rst_arvalid", 128'(m_arvalid), 128'd0);
      check("rst_rready", 128'(m_rready), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_flags", 128'({error, mismatch}), 128'd0);
      check("rst_name", name, 128'd0);
      check("rst_versions", 128'({major_version, minor_version}), 128'd0);
      aresetn = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // start re-pulsed during the scan and in the DONE cycle must be ignored
      load(vecs[0]);
      @(negedge aclk);
      push_addrs(5);
      ar0 = ar_hs_cnt; d0 = done_cnt;
      start = 1'b1; t0 = cyc;
      for (int k = 1; k <= 12; k++) begin
         @(negedge aclk);
         start = (k == 3 || k == 11);
      end
      check("repulse_done_count", 128'(done_cnt - d0), 128'd1);
      check("repulse_ar_count", 128'(ar_hs_cnt - ar0), 128'd5);
      check("repulse_idle", 128'(busy), 128'd0);
      push_addrs(5);
      start = 1'b1; t0 = cyc;
      @(negedge aclk);
      start = 1'b0;
      check("restart_busy", 128'(busy), 128'd1);
      check("restart_name_clear", name, 128'd0);
      check("restart_major_clear", 128'(major_version), 128'd0);
      wait_and_check(vecs[0], t0);

      // asynchronous reset while reading NAME2
      load(vecs[0]);
      @(negedge aclk);
      push_addrs(5);
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      repeat (5) @(negedge aclk);
      check("rready_in_data2", 128'(m_rready), 128'd1);
      #1 aresetn = 1'b0;
      #1;
      check("arst_rready", 128'(m_rready), 128'd0);
      check("arst_arvalid", 128'(m_arvalid), 128'd0);
      check("arst_busy", 128'(busy), 128'd0);
      check("arst_name", name, 128'd0);
      exp_q.delete();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_identifier_reader
`default_nettype wire
